// File: rtl/jtkcpu_simctrl_if.sv
// jtkcpu_simctrl CPU-side register bus.
// Master is the CPU/bench side, slave is the peripheral.
interface jtkcpu_simctrl_if;
  logic       cs;
  logic [2:0] addr;
  logic       we;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (
    output cs, addr, we, din,
    input  dout
  );

  modport slave (
    input  cs, addr, we, din,
    output dout
  );
endinterface

// File: rtl/jtkcpu_simctrl.sv
// Simulation control and interrupt stimulus for jtkcpu.
// Optional watchdog: define JTKCPU_SIMCTRL_WDOG_EN.
module jtkcpu_simctrl #(
  parameter int FINISH_DLY = 20,
  parameter int NMI_LEN    = 8
`ifdef JTKCPU_SIMCTRL_WDOG_EN
  , parameter int WDOG_CYC = 4096
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic cen2,
  jtkcpu_simctrl_if.slave bus,
  output logic nmi,
  output logic firq,
  output logic irq,
  output logic sim_bad,
  output logic done
);

  localparam int NW = $clog2(NMI_LEN + 1);
  localparam int FW = $clog2(FINISH_DLY + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DONE
  } st_t;

  st_t           state;
  logic [FW-1:0] fcnt;
  logic          s_nmi;
  logic          s_firq;
  logic          s_irq;
  logic [15:0]   reload;
  logic [15:0]   cnt;
  logic          t_en;
  logic          t_auto;
  logic [1:0]    t_tgt;
  logic          expired;
  logic          irq_pend;
  logic          firq_pend;
  logic [NW-1:0] nmi_cnt;
  logic [7:0]    sel;
  logic          wr;
  logic          fire;
  logic          start;
  logic          armed;
  logic          wd_hit;
  logic          wd_flag;

  assign sel   = 8'b1 << bus.addr;
  assign wr    = bus.cs & bus.we & cen2;
  assign fire  = t_en & cen & (cnt == 16'd0);
  assign start = (wr & sel[0] & bus.din[0]) | wd_hit;
  assign armed = state != ST_IDLE;

`ifdef JTKCPU_SIMCTRL_WDOG_EN
  logic [15:0] wd_cnt;
  logic        wd_armed;
  logic        wd_trip;
  logic        kick;

  assign kick    = wr & sel[5];
  assign wd_hit  = wd_armed & ~wd_trip & cen & ~kick
                 & (wd_cnt == 16'(WDOG_CYC - 1));
  assign wd_flag = wd_trip;

  // Watchdog: armed by the first kick, trips once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt   <= 16'd0;
      wd_armed <= 1'b0;
      wd_trip  <= 1'b0;
    end else if (kick) begin
      wd_armed <= 1'b1;
      wd_cnt   <= 16'd0;
    end else if (wd_hit) begin
      wd_trip  <= 1'b1;
    end else if (wd_armed & ~wd_trip & cen) begin
      wd_cnt   <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign wd_flag = 1'b0;
`endif

  // Register file, timer and status; expiry wins over W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_nmi     <= 1'b0;
      s_firq    <= 1'b0;
      s_irq     <= 1'b0;
      sim_bad   <= 1'b0;
      reload    <= 16'd0;
      cnt       <= 16'd0;
      t_en      <= 1'b0;
      t_auto    <= 1'b0;
      t_tgt     <= 2'd0;
      expired   <= 1'b0;
      irq_pend  <= 1'b0;
      firq_pend <= 1'b0;
      nmi_cnt   <= '0;
    end else begin
      if (wr & sel[0]) begin
        s_nmi   <= bus.din[7];
        s_firq  <= bus.din[6];
        s_irq   <= bus.din[5];
        sim_bad <= bus.din[1];
      end
      if (wd_hit)
        sim_bad <= 1'b1;
      if (wr & sel[1])
        reload[7:0] <= bus.din;
      if (wr & sel[2])
        reload[15:8] <= bus.din;
      if (t_en & cen) begin
        if (cnt == 16'd0) begin
          if (t_auto)
            cnt <= reload;
          else
            t_en <= 1'b0;
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
      if (cen & (nmi_cnt != '0))
        nmi_cnt <= nmi_cnt - 1'b1;
      if (wr & sel[4]) begin
        expired   <= expired   & ~bus.din[0];
        irq_pend  <= irq_pend  & ~bus.din[1];
        firq_pend <= firq_pend & ~bus.din[2];
      end
      if (fire) begin
        expired <= 1'b1;
        case (t_tgt)
          2'd1:    irq_pend  <= 1'b1;
          2'd2:    firq_pend <= 1'b1;
          2'd3:    nmi_cnt   <= NW'(NMI_LEN);
          default: ;
        endcase
      end
      if (wr & sel[3]) begin
        t_en   <= bus.din[0];
        t_auto <= bus.din[1];
        t_tgt  <= bus.din[3:2];
        if (bus.din[0])
          cnt <= reload;
      end
    end
  end

  // Finish sequencer: drain FINISH_DLY clk, then one done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      fcnt  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_DRAIN;
            fcnt  <= '0;
          end
        end
        ST_DRAIN: begin
          if (fcnt == FW'(FINISH_DLY - 1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Interrupt lines registered from static levels and pendings
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi  <= 1'b0;
      firq <= 1'b0;
      irq  <= 1'b0;
    end else begin
      nmi  <= s_nmi  | (nmi_cnt != '0);
      firq <= s_firq | firq_pend;
      irq  <= s_irq  | irq_pend;
    end
  end

  // Read mux
  always_comb begin
    bus.dout = 8'h00;
    unique case (1'b1)
      sel[0]: bus.dout = {s_nmi, s_firq, s_irq, 3'b000, sim_bad, armed};
      sel[1]: bus.dout = reload[7:0];
      sel[2]: bus.dout = reload[15:8];
      sel[3]: bus.dout = {4'b0000, t_tgt, t_auto, t_en};
      sel[4]: bus.dout = {3'b000, wd_flag, nmi_cnt != '0,
                          firq_pend, irq_pend, expired};
      default: bus.dout = 8'h00;
    endcase
  end

endmodule

// File: doc/jtkcpu_simctrl.md
Name: jtkcpu_simctrl

Overview:
- Memory-mapped simulation-control and interrupt-stimulus peripheral on the jtkcpu data bus, decoded by the bench at 0x1000-0x1007.
- Takes CPU register writes.
- Drives the CPU interrupt inputs (nmi/firq/irq) from a static register plus a programmable countdown timer.
- Produces finish and pass/fail flags after a fixed drain delay.

Parameters:
- FINISH_DLY, 20, clk cycles from the finish request to the done pulse.
- NMI_LEN, 8, cen ticks a timer-generated NMI pulse stays high.
- WDOG_CYC, 4096, cen ticks before the watchdog trips (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- cen  in  1  CPU clock enable (1 in 4 clk)
- cen2  in  1  half-rate enable; qualifies bus writes
- cs  in  1  peripheral select
- addr  in  3  register offset
- we  in  1  CPU write strobe
- din  in  8  CPU write data
- dout  out  8  read data (combinational from registers)
- nmi  out  1  active-high NMI request to CPU
- firq  out  1  active-high FIRQ request
- irq  out  1  active-high IRQ request
- sim_bad  out  1  failure flag
- done  out  1  one-clk pulse: simulation end

Behaviour:
- Write strobe: wr = cs & we & cen2.
  - One register update per wr clk.
  - Repeated strobes within a bus cycle rewrite the same value and must be idempotent, except offset 4, which is write-1-to-clear.
- Offset 0, CTRL:
  - bit0=1 arms the finish counter.
  - bit1 loads sim_bad.
  - bits7:5 load the static levels {s_nmi,s_firq,s_irq}.
  - Reads return {s_nmi,s_firq,s_irq,3'b0,sim_bad,armed}.
- Offsets 1 and 2: timer reload, low and high byte (16 bits). Read back as written.
- Offset 3, TCTRL:
  - bit0 enable.
  - bit1 auto-reload.
  - bits3:2 target: 0 none, 1 irq, 2 firq, 3 nmi.
  - Writing with bit0=1 loads count := reload on the same clk.
- Offset 4, STATUS:
  - bit0 expired flag (sticky).
  - bit1 timer-irq pending.
  - bit2 timer-firq pending.
  - bit3 NMI pulse active.
  - Write 1 to a bit to clear it; bit3 is not clearable.
- Offset 5: watchdog kick (optional feature); ignored otherwise.
- Offsets 6 and 7: read 0, writes ignored.
- Timer:
  - When enabled, count decrements by 1 on each cen.
  - On count==0 with cen:
    - expired is set.
    - The pending bit of the target is set; for target nmi, the NMI pulse counter loads NMI_LEN.
    - With auto-reload, count := reload; otherwise enable clears.
  - reload==0 with auto-reload fires on every cen.
  - Expiry and a STATUS clear in the same clk: set wins.
- Outputs:
  - irq = s_irq | irq_pend.
  - firq = s_firq | firq_pend.
  - nmi = s_nmi | (nmi_cnt!=0).
  - All three are registered; 1 clk latency after the write or expiry.
- NMI pulse counter:
  - Decrements on cen while nonzero.
  - A fresh expiry while the counter is nonzero reloads NMI_LEN. No second edge is produced; the CPU sees the pulse merely extended.
- Finish FSM: IDLE -> DRAIN on CTRL bit0 write; DRAIN counts FINISH_DLY clk; -> DONE.
  - DONE asserts done for 1 clk, then returns to IDLE.
  - sim_bad keeps its last written value.
  - Further CTRL bit0 writes during DRAIN do not restart the count.
- Reset (async, rst_n=0), all at 0:
  - all registers and counters
  - dout source registers
  - nmi/firq/irq
  - sim_bad
  - done
  - FSM in IDLE
- Reset mid-DRAIN aborts the count; no done pulse is produced.

Optional Feature:
- Macro: JTKCPU_SIMCTRL_WDOG_EN.
- Defined:
  - A 16-bit watchdog counts cen ticks.
  - It is cleared by any write to offset 5, and only after it is armed by the first such write.
  - Reaching WDOG_CYC forces sim_bad=1 and starts the finish FSM as if CTRL bit0 had been written.
  - STATUS bit4 reads 1 once the watchdog has tripped.
- Undefined:
  - No watchdog logic.
  - Offset 5 writes are ignored.
  - STATUS bit4 reads 0.

Test Plan:
- Write CTRL=0x01 -> done pulses exactly FINISH_DLY(20) clk later; sim_bad=0. Write CTRL=0x03 -> done pulses with sim_bad=1.
- Write CTRL=0xA0 -> nmi=1, firq=0, irq=1 one clk after wr. Write CTRL=0x00 -> all three low.
- Reload=0x0003, TCTRL=0x05 (enable, target irq) -> irq rises after 4 cen ticks and stays high. Write STATUS=0x02 -> irq drops; no refire, since enable has cleared.
- Reload=0x0002, TCTRL=0x0F (auto-reload, nmi) -> nmi high for 8 cen every 3 cen ticks. Observe a continuous high without a gap (pulse extended).
- Assert rst_n=0 mid-DRAIN and mid-timer -> all outputs 0 immediately. No done pulse after release.
- With JTKCPU_SIMCTRL_WDOG_EN, WDOG_CYC=16: kick once, then stop -> after 16 cen, sim_bad=1, and done pulses 20 clk later.
